// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Instruction queue between fetch and decode. Every instruction word that
// fetch loads is captured with its PC in a small circular FIFO. Decode drains
// the head through a valid/ready handshake, so a short decode stall does not
// immediately back-pressure fetch. A redirect (flush) empties the queue in a
// single cycle.
//
// Optional feature macro: IFQ_STALL_COUNT_EN adds a saturating 16-bit counter
// of cycles in which fetch presented an instruction to a full queue.
//
// Ports
//   clk                     single clock, rising edge
//   rst_n                   asynchronous active-low reset
//   enq_valid/pc/instr      fetch-side entry
//   enq_ready               queue not full (fetch stall = ~enq_ready)
//   deq_valid/pc/instr      head entry (zeros, i.e. a NOP, when empty)
//   deq_ready               decode consumes the head
//   flush                   redirect: drop everything, including this cycle's enq
//   count                   occupancy, 0..DEPTH
//   full_stall_count_reset  clear stall counter (macro only)
//   full_stall_count        stall counter (macro only)
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    input  logic [15:0]                enq_pc,
    input  logic [15:0]                enq_instr,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [15:0]                deq_pc,
    output logic [15:0]                deq_instr,
    input  logic                       deq_ready,
    input  logic                       flush,
`ifdef IFQ_STALL_COUNT_EN
    input  logic                       full_stall_count_reset,
    output logic [15:0]                full_stall_count,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] head_reg, head_next;
    logic [AW:0] tail_reg, tail_next;

    logic        empty;
    logic        full;
    logic        enq_fire;
    logic        deq_fire;
    logic [31:0] entry_arr [DEPTH];

    assign empty     = (head_reg == tail_reg);
    assign full      = (head_reg[AW-1:0] == tail_reg[AW-1:0]) &&
                       (head_reg[AW] != tail_reg[AW]);
    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    // For a power-of-two depth the pointer difference is the occupancy.
    assign count     = CW'(tail_reg - head_reg);

    // Readiness comes from registered state only, so a same-cycle dequeue
    // never frees a slot for a same-cycle enqueue.
    assign enq_fire  = enq_valid & enq_ready & ~flush;
    assign deq_fire  = deq_valid & deq_ready & ~flush;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (flush) begin
            head_next = '0;
            tail_next = '0;
        end else begin
            if (enq_fire) tail_next = tail_reg + PTR_ONE;
            if (deq_fire) head_next = head_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    // Entry storage: contents need no reset, validity comes from the pointers.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] entry_reg;
            always_ff @(posedge clk) begin
                if (enq_fire && (tail_reg[AW-1:0] == AW'(gi)))
                    entry_reg <= {enq_pc, enq_instr};
            end
            assign entry_arr[gi] = entry_reg;
        end
    endgenerate

    // Empty queue presents an all-zero word (BR never == NOP) to decode.
    assign {deq_pc, deq_instr} = deq_valid ? entry_arr[head_reg[AW-1:0]] : 32'h0;

`ifdef IFQ_STALL_COUNT_EN
    logic [15:0] stall_cnt_reg, stall_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (full_stall_count_reset)
            stall_cnt_next = 16'h0000;
        else if (enq_valid && !enq_ready && !flush && (stall_cnt_reg != 16'hFFFF))
            stall_cnt_next = stall_cnt_reg + 16'h0001;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_reg <= 16'h0000;
        else        stall_cnt_reg <= stall_cnt_next;
    end

    assign full_stall_count = stall_cnt_reg;
`endif

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode. Each instruction word returned to fetch is captured together with its PC in a small circular FIFO. Decode drains the FIFO through a valid/ready handshake, so a one-cycle decode stall no longer forces fetch to stall. Branch, trap and JMP/JSR redirects flush the queue in one cycle.

## Interface

Parameters
- `DEPTH`, default 4: number of entries; must be a power of two, 2..8.

Ports
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enq_valid`, in, 1: fetch presents an instruction. Asserted for exactly the cycles in which fetch loads its IR (memory response, not stalled).
- `enq_pc`, in, 16 (`lc3b_word`): PC of the presented instruction.
- `enq_instr`, in, 16 (`lc3b_word`): instruction word.
- `enq_ready`, out, 1: queue can accept an entry. Fetch drives its `stall` from `~enq_ready`.
- `deq_valid`, out, 1: head entry is valid.
- `deq_pc`, out, 16: PC of the head entry.
- `deq_instr`, out, 16: instruction of the head entry.
- `deq_ready`, in, 1: decode consumes the head this cycle.
- `flush`, in, 1: redirect; assert as `br_en | trap_en | jmp_jsr_en`.
- `count`, out, `$clog2(DEPTH+1)`: current occupancy.
- `full_stall_count_reset`, in, 1: synchronous clear of the stall counter (present only with the macro).
- `full_stall_count`, out, 16: stall counter (present only with the macro).

## Operation

- Storage: `DEPTH` entries of {pc[15:0], instr[15:0]}.
  - `head` and `tail` pointers are `$clog2(DEPTH)` bits plus one wrap bit.
  - Empty: pointers equal including the wrap bit.
  - Full: index bits equal and wrap bits differ.
- Enqueue fires on `enq_valid & enq_ready & ~flush`: write the entry at `tail`, then `tail++`.
  - `enq_valid` while `~enq_ready` is ignored; data is not stored.
- Dequeue fires on `deq_valid & deq_ready & ~flush`: `head++`.
  - `deq_ready` while `~deq_valid` has no effect.
- Enqueue and dequeue in the same cycle: both fire; `count` is unchanged.
- `enq_ready = (count != DEPTH)`.
  - No bypass on full: a same-cycle dequeue does not make room for a same-cycle enqueue.
- `deq_valid = (count != 0)`.
  - When empty, `deq_pc = 16'h0000` and `deq_instr = 16'h0000` (BR never, i.e. a NOP).
  - There is no bypass from enq to deq. A written entry is visible the cycle after the write.
- `flush`:
  - Sets `head = tail = 0` and `count = 0`.
  - Has priority over both enqueue and dequeue in the same cycle. The entry presented in the flush cycle is dropped, because fetch is loading the redirect target PC in that cycle.
- Pointer wrap: index bits roll from `DEPTH-1` to 0 and the wrap bit toggles. No entry is lost or duplicated across the wrap.

## Timing

- Reset values (asynchronous, while `rst_n`=0):
  - `head`, `tail`, `count` = 0.
  - `deq_valid` = 0; `deq_pc`, `deq_instr` = 0.
  - `enq_ready` = 1.
  - `full_stall_count` = 0.
  - Entry contents are don't-care.
- Reset deasserted mid-operation: the queue restarts empty; all prior entries are discarded.
- Latency: an enqueue at edge N gives `deq_valid`=1 with that entry after edge N, i.e. one cycle.
- Throughput: one enqueue and one dequeue per cycle in steady state.
- `enq_ready`, `deq_valid`, `deq_pc`, `deq_instr`, `count` are functions of registered state only. There is no combinational path from any input to any output.

## Configuration

- `IFQ_STALL_COUNT_EN` defined:
  - A 16-bit counter increments on every cycle with `enq_valid & ~enq_ready & ~flush`.
  - It saturates at `16'hFFFF`.
  - `full_stall_count_reset`=1 clears it on the next edge, with priority over the increment.
- `IFQ_STALL_COUNT_EN` undefined: the counter, `full_stall_count_reset` and `full_stall_count` are removed from the module.

## Test plan

- **Basic fill/drain:** after reset, enqueue PC 0x0000/0x0002/0x0004 with instr 0x1261/0x1482/0x16C3, `deq_ready`=0.
  - `count`=3, `deq_pc`=0x0000, `deq_instr`=0x1261.
  - Then `deq_ready`=1 for 3 cycles: outputs appear in FIFO order, then `deq_valid`=0 with `deq_instr`=0x0000.
- **Full:** `DEPTH`=4, enqueue 5 entries with `deq_ready`=0.
  - `enq_ready`=0 after the 4th; the 5th is not stored; `count`=4.
  - With the macro, `full_stall_count`=1.
- **Full with simultaneous deq/enq:** queue full, `enq_valid`=1, `deq_ready`=1.
  - Head dequeued, no enqueue that cycle, `count`=3, `enq_ready`=1 the next cycle.
- **Flush priority:** 2 entries queued; in one cycle assert `flush`=1, `enq_valid`=1 (PC 0x3000), `deq_ready`=1.
  - Next cycle: `count`=0, `deq_valid`=0.
  - The following enqueue of PC 0x3000 appears alone at the head.
- **Wrap-around:** run 10 interleaved enq/deq with PCs 0x0000..0x0012 step 2.
  - The dequeued sequence matches the enqueued one exactly across two pointer wraps.
- **Async reset mid-stream:** pulse `rst_n`=0 between edges with 3 entries queued.
  - Immediately `deq_valid`=0, `count`=0, `enq_ready`=1, `full_stall_count`=0.
